// File: rtl/wos_pkg.sv
// Shared helpers for the weighted order-statistic window filter: width derivations,
// default threshold, window-length legality and the flush-time rank pattern.
package wos_pkg;

    function automatic int rank_bits_f(input int n);
        return $clog2(n);
    endfunction

    function automatic int sum_bits_f(input int n, input int wb);
        return $clog2(n * (2 ** wb - 1) + 1);
    endfunction

    function automatic int default_thresh(input int n);
        return (n + 1) / 2;
    endfunction

    function automatic bit len_is_legal(input int len, input int n);
        return (len % 2 == 1) && (len >= 3) && (len <= n);
    endfunction

    // Flushed window holds equal zeros; newer taps rank above older ones.
    function automatic int flush_rank(input int tap, input int len);
        return (tap < len) ? (len - 1 - tap) : 0;
    endfunction

endpackage

// File: rtl/wos_window_filter_rank_cell.sv
// Per-tap incremental rank update: compares the tap against the incoming sample
// and closes the gap left by the evicted tap.
module wos_rank_cell
    import wos_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int RANK_BITS = 3
) (
    input  logic [DATA_BITS-1:0] data,
    input  logic [RANK_BITS-1:0] rank,
    input  logic [DATA_BITS-1:0] new_data,
    input  logic [RANK_BITS-1:0] ev_rank,
    output logic                 le,
    output logic [RANK_BITS-1:0] next_rank
);

    logic inc;
    logic dec;

    // On ties the new sample ranks above, so an equal tap is not pushed up.
    assign le        = (data <= new_data);
    assign inc       = (new_data < data);
    assign dec       = (rank > ev_rank);
    assign next_rank = rank + RANK_BITS'(inc) - RANK_BITS'(dec);

endmodule

// File: rtl/wos_window_filter.sv
// Streaming weighted order-statistic filter over a runtime-selectable odd window,
// with incremental rank tracking, valid/ready handshake and a two-stage pipeline.
module wos_window_filter
    import wos_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int N         = 7,
    parameter int W_BITS    = 2,
    parameter int RANK_BITS = rank_bits_f(N),
    parameter int SUM_BITS  = sum_bits_f(N, W_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_load,
    input  logic [RANK_BITS:0]    cfg_len,
    input  logic [SUM_BITS-1:0]   cfg_thresh,
    input  logic [N*W_BITS-1:0]   cfg_weights,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_BITS-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_BITS-1:0]  out_data
);

    logic [RANK_BITS:0]    len_reg;
    logic [SUM_BITS-1:0]   thresh_reg;
    logic [N*W_BITS-1:0]   weights_reg;
    logic [DATA_BITS-1:0]  tap_data_reg [N];
    logic [RANK_BITS-1:0]  tap_rank_reg [N];
    logic [RANK_BITS:0]    fill_reg;
    logic                  a_valid_reg;
    logic                  a_filled_reg;
    logic                  out_valid_reg;
    logic [DATA_BITS-1:0]  out_data_reg;

    logic [RANK_BITS:0]    len_load;
    logic [SUM_BITS-1:0]   thresh_load;
    logic [RANK_BITS:0]    fill_next;
    logic                  filled_next;
    logic                  b_adv;
    logic                  accept;
    logic [RANK_BITS-1:0]  ev_rank;
    logic [RANK_BITS-1:0]  new_rank;
    logic [N-2:0]          le;
    logic [RANK_BITS-1:0]  cell_rank [N-1];
    logic [DATA_BITS-1:0]  shift_data [N];
    logic [RANK_BITS-1:0]  shift_rank [N];
    logic [N-1:0]          qualify;
    logic [N-1:0]          is_last;
    logic [DATA_BITS-1:0]  sel_data;
    logic [DATA_BITS-1:0]  fall_data;
    logic [RANK_BITS-1:0]  best_rank;
    logic                  sel_found;

    assign len_load    = len_is_legal(int'(cfg_len), N) ? cfg_len : (RANK_BITS+1)'(N);
    assign thresh_load = (cfg_thresh == '0) ? SUM_BITS'(1) : cfg_thresh;

    assign b_adv       = !out_valid_reg || out_ready;
    assign in_ready    = (!a_valid_reg || b_adv) && !cfg_load;
    assign accept      = in_valid && in_ready;
    assign fill_next   = (fill_reg >= len_reg) ? len_reg : fill_reg + (RANK_BITS+1)'(1);
    assign filled_next = (fill_next == len_reg);

    always_comb begin
        ev_rank = '0;
        for (int i = 0; i < N; i++) begin
            if (i == int'(len_reg) - 1) ev_rank = tap_rank_reg[i];
        end
    end

    always_comb begin
        new_rank = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (i < int'(len_reg) - 1 && le[i]) new_rank = new_rank + RANK_BITS'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_tap
            logic [SUM_BITS-1:0] sum_acc;

            // The oldest possible tap never survives a shift, so it needs no cell.
            if (gi < N - 1) begin : g_cell
                wos_rank_cell #(
                    .DATA_BITS (DATA_BITS),
                    .RANK_BITS (RANK_BITS)
                ) u_cell (
                    .data      (tap_data_reg[gi]),
                    .rank      (tap_rank_reg[gi]),
                    .new_data  (in_data),
                    .ev_rank   (ev_rank),
                    .le        (le[gi]),
                    .next_rank (cell_rank[gi])
                );
            end

            if (gi == 0) begin : g_head
                assign shift_data[gi] = in_data;
                assign shift_rank[gi] = new_rank;
            end else begin : g_body
                assign shift_data[gi] = tap_data_reg[gi-1];
                assign shift_rank[gi] = cell_rank[gi-1];
            end

            always_comb begin
                sum_acc = '0;
                for (int i = 0; i < N; i++) begin
                    if (i < int'(len_reg) && tap_rank_reg[i] <= tap_rank_reg[gi])
                        sum_acc = sum_acc + SUM_BITS'(weights_reg[i*W_BITS +: W_BITS]);
                end
            end

            assign qualify[gi] = (gi < int'(len_reg)) && (sum_acc >= thresh_reg);
            assign is_last[gi] = (gi < int'(len_reg)) &&
                                 (tap_rank_reg[gi] == RANK_BITS'(int'(len_reg) - 1));
        end
    endgenerate

    always_comb begin
        sel_data  = '0;
        fall_data = '0;
        best_rank = '0;
        sel_found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (is_last[j]) fall_data = tap_data_reg[j];
            if (qualify[j] && (!sel_found || tap_rank_reg[j] < best_rank)) begin
                sel_found = 1'b1;
                best_rank = tap_rank_reg[j];
                sel_data  = tap_data_reg[j];
            end
        end
        if (!sel_found) sel_data = fall_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_reg     <= (RANK_BITS+1)'(N);
            thresh_reg  <= SUM_BITS'(default_thresh(N));
            weights_reg <= {N{W_BITS'(1)}};
        end else if (cfg_load) begin
            len_reg     <= len_load;
            thresh_reg  <= thresh_load;
            weights_reg <= cfg_weights;
        end
    end

    // The window registers double as stage A data: they only change on accept,
    // which is exactly when stage A loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                tap_data_reg[i] <= '0;
                tap_rank_reg[i] <= RANK_BITS'(flush_rank(i, N));
            end
            fill_reg <= '0;
        end else if (cfg_load) begin
            for (int i = 0; i < N; i++) begin
                tap_data_reg[i] <= '0;
                tap_rank_reg[i] <= RANK_BITS'(flush_rank(i, int'(len_load)));
            end
            fill_reg <= '0;
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                if (i < int'(len_reg)) begin
                    tap_data_reg[i] <= shift_data[i];
                    tap_rank_reg[i] <= shift_rank[i];
                end
            end
            fill_reg <= fill_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid_reg   <= 1'b0;
            a_filled_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (cfg_load) begin
            a_valid_reg   <= 1'b0;
            a_filled_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                a_valid_reg  <= 1'b1;
                a_filled_reg <= filled_next;
            end else if (b_adv) begin
                a_valid_reg  <= 1'b0;
            end
            if (b_adv) begin
                out_valid_reg <= a_valid_reg && a_filled_reg;
                if (a_valid_reg && a_filled_reg) out_data_reg <= sel_data;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_wos_window_filter.sv
// Table-driven and scoreboard bench for wos_window_filter with a sort-based reference.
module tb_wos_window_filter;

    localparam int DB = 8;
    localparam int N  = 7;
    localparam int WB = 2;
    localparam int RB = 3;
    localparam int SB = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_load = 1'b0;
    logic [RB:0]       cfg_len = '0;
    logic [SB-1:0]     cfg_thresh = '0;
    logic [N*WB-1:0]   cfg_weights = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DB-1:0]     in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DB-1:0]     out_data;

    always #5 clk = ~clk;

    wos_window_filter #(.DATA_BITS(DB), .N(N), .W_BITS(WB)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_len     (cfg_len),
        .cfg_thresh  (cfg_thresh),
        .cfg_weights (cfg_weights),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    typedef struct {
        bit          cfg;
        logic [3:0]  len;
        logic [4:0]  t;
        logic [13:0] w;
        logic [7:0]  din;
        bit          he;
        logic [7:0]  exp;
    } row_t;

    row_t        tbl[$];
    logic [7:0]  hist[$];
    logic [7:0]  sb[$];
    int          m_len = N;
    int          m_t = 4;
    int          m_w[N];
    int          checks = 0;
    int          errors = 0;
    int          stall_left = 0;
    int          stall_acc = 0;
    bit          ready_low_seen = 0;
    bit          held = 0;
    logic [7:0]  held_data;
    bit          pend_he = 0;
    logic [7:0]  pend_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [7:0] ref_out();
        int         rk[N];
        int         s;
        bit         found;
        logic [7:0] res;
        found = 0;
        res = '0;
        for (int i = 0; i < m_len; i++) begin
            rk[i] = 0;
            for (int j = 0; j < m_len; j++)
                if (j != i && (hist[j] < hist[i] || (hist[j] == hist[i] && j > i))) rk[i]++;
        end
        for (int r = 0; r < m_len; r++) begin
            s = 0;
            for (int k = 0; k < m_len; k++) if (rk[k] <= r) s += m_w[k];
            if (!found && s >= m_t) begin
                found = 1;
                for (int i = 0; i < m_len; i++) if (rk[i] == r) res = hist[i];
            end
        end
        if (!found)
            for (int i = 0; i < m_len; i++) if (rk[i] == m_len - 1) res = hist[i];
        return res;
    endfunction

    task automatic model_reset();
        hist.delete();
        sb.delete();
        held = 0;
        m_len = N;
        m_t = 4;
        for (int i = 0; i < N; i++) m_w[i] = 1;
    endtask

    task automatic model_accept(input logic [7:0] d);
        hist.push_front(d);
        while (hist.size() > m_len) void'(hist.pop_back());
        if (pend_he) sb.push_back(pend_exp);
        else if (hist.size() == m_len) sb.push_back(ref_out());
    endtask

    task automatic model_cfg();
        int l;
        l = int'(cfg_len);
        m_len = (l % 2 == 1 && l >= 3 && l <= N) ? l : N;
        m_t = (cfg_thresh == 0) ? 1 : int'(cfg_thresh);
        for (int i = 0; i < N; i++) m_w[i] = int'(cfg_weights[i*WB +: WB]);
        hist.delete();
        sb.delete();
        held = 0;
    endtask

    // One clock: entered just after a falling edge, returns at the next falling edge.
    task automatic step(output bit acc);
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        #1;
        if (held) check("hold_stable", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held_data});
        held = out_valid && !out_ready && !cfg_load;
        held_data = out_data;
        if (out_valid && out_ready && !cfg_load) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0d required=none", out_data);
            end else begin
                check("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
            end
        end
        if (cfg_load) check("in_ready_during_cfg", {31'd0, in_ready}, 32'd0);
        acc = in_valid && in_ready && !cfg_load;
        if (!out_ready) begin
            if (!in_ready) ready_low_seen = 1;
            if (acc) stall_acc++;
        end
        @(posedge clk);
        if (acc) model_accept(in_data);
        if (cfg_load) model_cfg();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic send(input logic [7:0] d, input bit he, input logic [7:0] e);
        bit acc;
        int tries;
        tries = 0;
        acc = 0;
        in_valid = 1'b1;
        in_data = d;
        pend_he = he;
        pend_exp = e;
        while (!acc && tries < 50) begin
            step(acc);
            tries++;
        end
        in_valid = 1'b0;
        pend_he = 0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic do_cfg(input logic [3:0] l, input logic [4:0] t, input logic [13:0] w);
        bit acc;
        cfg_load = 1'b1;
        cfg_len = l;
        cfg_thresh = t;
        cfg_weights = w;
        in_valid = 1'b1;
        in_data = 8'hAA;
        step(acc);
        cfg_load = 1'b0;
        in_valid = 1'b0;
        check("out_valid_after_cfg", {31'd0, out_valid}, 32'd0);
    endtask

    function automatic void add_cfg(input logic [3:0] l, input logic [4:0] t, input logic [13:0] w);
        row_t r;
        r = '{cfg: 1, len: l, t: t, w: w, din: 0, he: 0, exp: 0};
        tbl.push_back(r);
    endfunction

    function automatic void add_smp(input logic [7:0] d, input bit he, input logic [7:0] e);
        row_t r;
        r = '{cfg: 0, len: 0, t: 0, w: 0, din: d, he: he, exp: e};
        tbl.push_back(r);
    endfunction

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", {24'd0, out_data}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Median from reset defaults, weighted selection, ties.
        add_smp(5, 0, 0); add_smp(1, 0, 0); add_smp(9, 0, 0); add_smp(3, 0, 0);
        add_smp(7, 0, 0); add_smp(2, 0, 0); add_smp(8, 1, 5); add_smp(0, 1, 3);
        add_cfg(3, 2, 14'h006); add_smp(10, 0, 0); add_smp(20, 0, 0); add_smp(30, 1, 30);
        add_cfg(3, 1, 14'h006); add_smp(10, 0, 0); add_smp(20, 0, 0); add_smp(30, 1, 20);
        add_cfg(3, 3, 14'h006); add_smp(10, 0, 0); add_smp(20, 0, 0); add_smp(30, 1, 30);
        add_cfg(3, 4, 14'h006); add_smp(10, 0, 0); add_smp(20, 0, 0); add_smp(30, 1, 30);
        add_cfg(3, 2, 14'h1555);
        add_smp(7, 0, 0); add_smp(3, 0, 0); add_smp(7, 1, 7);
        add_smp(7, 1, 7); add_smp(3, 1, 7); add_smp(0, 1, 3);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].cfg) begin
                idle(4);
                check("drained_before_cfg", sb.size(), 32'd0);
                do_cfg(tbl[i].len, tbl[i].t, tbl[i].w);
            end else begin
                send(tbl[i].din, tbl[i].he, tbl[i].exp);
            end
        end

        // Mid-stream flush to L=5, then first output from the 5th accept.
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 15)), 0, 0);
        check("out_valid_before_flush", {31'd0, out_valid}, 32'd1);
        do_cfg(5, 3, 14'h1555);
        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 15)), 0, 0);
        idle(3);
        send(8'($urandom_range(0, 15)), 0, 0);
        check("latency_t1", {31'd0, out_valid}, 32'd0);
        idle(1);
        check("latency_t2", {31'd0, out_valid}, 32'd1);

        // Backpressure: 5-cycle stall in a continuous stream.
        for (int i = 0; i < 30; i++) begin
            if (i == 10) stall_left = 5;
            send(8'($urandom_range(0, 15)), 0, 0);
        end
        idle(8);
        check("stall_in_ready_low", {31'd0, ready_low_seen}, 32'd1);
        check("stall_accepts_le2", {31'd0, stall_acc <= 2}, 32'd1);
        check("drained_after_stall", sb.size(), 32'd0);

        // Asynchronous reset mid-stream, then an illegal length.
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 15)), 0, 0);
        #2 rst = 1'b0;
        #1;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_out_data", {24'd0, out_data}, 32'd0);
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        do_cfg(4, 4, 14'h1555);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 15)), 0, 0);
        idle(3);
        send(8'($urandom_range(0, 15)), 0, 0);
        idle(4);
        check("drained_after_len4", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
